blockmatch_scheduler: RTL and testbench
=======================================

// Module: blockmatch_scheduler
// PURPOSE
// - Sequences block-match requests across a frame: emits (blk_col, blk_row) plus pixel origin to the matcher, one block row at a time.
// - Gates each row on a free ping-pong row buffer in the downstream xor/disparity stream stage, so writers never overrun readers.
// - Caps outstanding matcher work; tracks completions; flags protocol errors.
// PARAMETERS
// - BLK_W         16   block width, pixels
// - BLK_H         16   block height, pixels
// - FRAME_W       240  frame width, pixels
// - FRAME_H       240  frame height, pixels
// - SEARCH_BLK_W  48   search window width; BPR = (FRAME_W-SEARCH_BLK_W)/BLK_W = 12 blocks/row
// - NUM_BUFS      2    downstream row buffers (credits)
// - MAX_INFLIGHT  4    max issued-but-uncompleted requests
// PORTS
// - clk           in   1        clock
// - reset         in   1        synchronous, active-high
// - frame_start   in   1        pulse: begin a frame (accepted only in IDLE)
// - req_valid     out  1        request valid
// - req_ready     in   1        matcher accepts; transfer = req_valid & req_ready
// - req_blk_col   out  clog2(BPR)   block column
// - req_blk_row   out  clog2(FRAME_H/BLK_H)  block row
// - req_x         out  16       pixel x origin = blk_col*BLK_W
// - req_y         out  16       pixel y origin = blk_row*BLK_H
// - req_row_last  out  1        request is last block of its row
// - res_valid     in   1        matcher completion pulse (same as downstream xors_valid)
// - buf_release   in   1        pulse: downstream finished streaming one row buffer
// - busy          out  1        not IDLE
// - frame_done    out  1        1-cycle pulse after final completion of frame
// - err_spurious  out  1        sticky: res_valid with inflight==0
// - err_release   out  1        sticky: buf_release with credits==NUM_BUFS
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; credits=NUM_BUFS; inflight=0; col/row=0; errors cleared.
// - States: IDLE -> (frame_start) ACQ -> ISSUE -> ROW_WAIT -> ACQ|FIN -> IDLE.
// - ACQ: if credits>0, take one credit, go ISSUE next cycle; else hold. frame_start->first req_valid = 2 cycles when credit free.
// - ISSUE: req_valid=1 iff inflight<MAX_INFLIGHT; fields registered, stable while valid & !ready.
//   On transfer: inflight+1, col+1; on col==BPR-1 transfer (req_row_last=1) -> ROW_WAIT, col=0.
// - ROW_WAIT: wait row completion count==BPR; then row+1 -> ACQ, or if last row -> FIN.
// - FIN: frame_done pulse 1 cycle, -> IDLE; credits not forced (downstream still draining).
// - Completion counter per row counts res_valid; may already be counting in ISSUE (pipelined matcher).
// - inflight: +1 on transfer, -1 on res_valid; simultaneous -> unchanged. Never exceeds MAX_INFLIGHT.
// - credits: -1 on ACQ take, +1 on buf_release; simultaneous -> unchanged. Saturates at NUM_BUFS (err_release set, no increment).
// - res_valid when inflight==0: ignored for counts, err_spurious set.
// - frame_start outside IDLE: ignored, no error.
// - req_x/req_y computed by shift when BLK_W/BLK_H power of 2, else accumulator; width 16, no wrap within frame.
// - Reset mid-frame: immediate return to reset state; in-flight results afterwards raise err_spurious (by design).
// STRUCTURE
// - Package bm_pkg: BPR, BLK_ROWS, width localparams via $clog2, sched_state_t enum {IDLE,ACQ,ISSUE,ROW_WAIT,FIN}.
// - Sub-module credit_counter #(MAX): up/down saturating counter with take/give/simultaneous handling and overflow flag; one instance each for credits and inflight.
// TESTING
// - Nominal: frame_start, req_ready=1, res_valid 3 cycles after each transfer, buf_release 20 cycles after each row -> 180 requests in raster order, frame_done once, no errors.
// - Backpressure: req_ready toggling 50% -> req fields stable while stalled; sequence identical to nominal.
// - Inflight cap: res_valid withheld -> exactly 4 transfers then req_valid=0; one res_valid -> one more transfer.
// - Buffer gating: buf_release never asserted -> rows 0,1 issued (24 requests), stall in ACQ; one buf_release -> row 2 starts.
// - Simultaneous: buf_release on ACQ-take cycle, res_valid on transfer cycle -> credits/inflight unchanged; spurious res_valid/extra release -> sticky errors.
// - Reset mid-row 5 -> all outputs 0 next cycle; new frame_start restarts at (0,0).

Source files
------------

// File: rtl/bm_pkg.sv
// rtl/bm_pkg.sv - frame geometry, derived widths and scheduler state encoding
package bm_pkg;

    localparam int BLK_W        = 16;
    localparam int BLK_H        = 16;
    localparam int FRAME_W      = 240;
    localparam int FRAME_H      = 240;
    localparam int SEARCH_BLK_W = 48;
    localparam int NUM_BUFS     = 2;
    localparam int MAX_INFLIGHT = 4;

    localparam int BPR      = (FRAME_W - SEARCH_BLK_W) / BLK_W;
    localparam int BLK_ROWS = FRAME_H / BLK_H;

    localparam int COL_W  = $clog2(BPR);
    localparam int ROW_W  = $clog2(BLK_ROWS);
    localparam int DONE_W = $clog2(BPR + 1);
    localparam int CRED_W = $clog2(NUM_BUFS + 1);
    localparam int IF_W   = $clog2(MAX_INFLIGHT + 1);

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(BPR - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(BLK_ROWS - 1);
    localparam logic [DONE_W-1:0] DONE_BPR = DONE_W'(BPR);
    localparam logic [IF_W-1:0]   IF_MAX   = IF_W'(MAX_INFLIGHT);

    // Power-of-two block sizes let the pixel origin come straight from the index.
    localparam bit W_POW2 = ((BLK_W & (BLK_W - 1)) == 0);
    localparam bit H_POW2 = ((BLK_H & (BLK_H - 1)) == 0);
    localparam int W_SH   = $clog2(BLK_W);
    localparam int H_SH   = $clog2(BLK_H);

    typedef enum logic [2:0] {
        IDLE,
        ACQ,
        ISSUE,
        ROW_WAIT,
        FIN
    } sched_state_t;

endpackage

// File: rtl/credit_counter.sv
// rtl/credit_counter.sv - saturating up/down counter with over/under flags
module credit_counter #(
    parameter int MAX  = 2,
    parameter int INIT = 0,
    parameter int W    = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         over,
    output logic         under
);

    localparam logic [W-1:0] CMAX  = W'(MAX);
    localparam logic [W-1:0] CINIT = W'(INIT);

    logic inc_ok;
    logic dec_ok;

    // A rejected inc/dec is dropped on its own; the other side still applies.
    always_comb begin
        over       = inc && (count == CMAX);
        under      = dec && (count == '0);
        inc_ok     = inc && !over;
        dec_ok     = dec && !under;
        count_next = count;
        if (inc_ok && !dec_ok) begin
            count_next = count + 1'b1;
        end else if (dec_ok && !inc_ok) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= CINIT;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/blockmatch_scheduler.sv
// rtl/blockmatch_scheduler.sv - raster-order block-match request sequencer gated on row buffers
module blockmatch_scheduler
    import bm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [COL_W-1:0] req_blk_col,
    output logic [ROW_W-1:0] req_blk_row,
    output logic [15:0]      req_x,
    output logic [15:0]      req_y,
    output logic             req_row_last,
    input  logic             res_valid,
    input  logic             buf_release,
    output logic             busy,
    output logic             frame_done,
    output logic             err_spurious,
    output logic             err_release
);

    sched_state_t      state;
    logic [CRED_W-1:0] credits;
    logic [CRED_W-1:0] credits_next;
    logic [IF_W-1:0]   inflight;
    logic [IF_W-1:0]   inflight_next;
    logic [DONE_W-1:0] done_cnt;
    logic              cr_over;
    logic              cr_under;
    logic              if_over;
    logic              if_under;
    logic              acq_take;
    logic              xfer;
    logic              res_ok;
    logic [COL_W-1:0]  col_n;
    logic [ROW_W-1:0]  row_n;
    logic              unused_bits;

    assign acq_take    = (state == ACQ) && (credits != '0);
    assign xfer        = req_valid && req_ready;
    assign res_ok      = res_valid && !if_under;
    assign col_n       = req_blk_col + 1'b1;
    assign row_n       = req_blk_row + 1'b1;
    assign unused_bits = &{1'b0, credits_next, cr_under, if_over};

    credit_counter #(.MAX(NUM_BUFS), .INIT(NUM_BUFS)) u_credits (
        .clk        (clk),
        .reset      (reset),
        .inc        (buf_release),
        .dec        (acq_take),
        .count      (credits),
        .count_next (credits_next),
        .over       (cr_over),
        .under      (cr_under)
    );

    credit_counter #(.MAX(MAX_INFLIGHT), .INIT(0)) u_inflight (
        .clk        (clk),
        .reset      (reset),
        .inc        (xfer),
        .dec        (res_valid),
        .count      (inflight),
        .count_next (inflight_next),
        .over       (if_over),
        .under      (if_under)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            req_valid    <= 1'b0;
            req_blk_col  <= '0;
            req_blk_row  <= '0;
            req_x        <= '0;
            req_y        <= '0;
            req_row_last <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            done_cnt     <= '0;
            err_spurious <= 1'b0;
            err_release  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (if_under) err_spurious <= 1'b1;
            if (cr_over)  err_release  <= 1'b1;
            // The matcher is pipelined, so completions can land while still issuing.
            if (res_ok && (state == ISSUE || state == ROW_WAIT)) begin
                done_cnt <= done_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state        <= ACQ;
                        busy         <= 1'b1;
                        req_blk_col  <= '0;
                        req_blk_row  <= '0;
                        req_x        <= '0;
                        req_y        <= '0;
                        req_row_last <= (BPR == 1);
                        done_cnt     <= '0;
                    end
                end
                ACQ: begin
                    if (credits != '0) begin
                        state     <= ISSUE;
                        req_valid <= (inflight_next < IF_MAX);
                    end
                end
                ISSUE: begin
                    if (xfer && req_row_last) begin
                        state        <= ROW_WAIT;
                        req_valid    <= 1'b0;
                        req_blk_col  <= '0;
                        req_x        <= '0;
                        req_row_last <= (BPR == 1);
                    end else begin
                        // Fields only advance on a transfer, so they hold while stalled.
                        if (xfer) begin
                            req_blk_col  <= col_n;
                            req_x        <= W_POW2 ? (16'(col_n) << W_SH) : (req_x + 16'(BLK_W));
                            req_row_last <= (col_n == COL_LAST);
                        end
                        req_valid <= (inflight_next < IF_MAX);
                    end
                end
                ROW_WAIT: begin
                    if (done_cnt == DONE_BPR) begin
                        done_cnt <= '0;
                        if (req_blk_row == ROW_LAST) begin
                            state      <= FIN;
                            frame_done <= 1'b1;
                        end else begin
                            state       <= ACQ;
                            req_blk_row <= row_n;
                            req_y       <= H_POW2 ? (16'(row_n) << H_SH) : (req_y + 16'(BLK_H));
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blockmatch_scheduler.sv
// tb/tb_blockmatch_scheduler.sv - randomized bench against a raster-order reference model
module tb_blockmatch_scheduler;
    import bm_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             frame_start;
    logic             req_valid;
    logic             req_ready;
    logic [COL_W-1:0] req_blk_col;
    logic [ROW_W-1:0] req_blk_row;
    logic [15:0]      req_x;
    logic [15:0]      req_y;
    logic             req_row_last;
    logic             res_valid;
    logic             buf_release;
    logic             busy;
    logic             frame_done;
    logic             err_spurious;
    logic             err_release;

    blockmatch_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_blk_col  (req_blk_col),
        .req_blk_row  (req_blk_row),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_row_last (req_row_last),
        .res_valid    (res_valid),
        .buf_release  (buf_release),
        .busy         (busy),
        .frame_done   (frame_done),
        .err_spurious (err_spurious),
        .err_release  (err_release)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    int cyc, k, n_xfer, n_done, n_rel, n_res, res12_iter, tb_out;
    int ready_pct, lat_res, lat_rel;
    bit extra_res, extra_rel, prev_stall;
    logic [31:0] p_xy, p_blk;
    int res_q[$];
    int rel_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: observe just after the edge, then choose inputs for the next edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (prev_stall) begin
            chk("stall_valid", {31'd0, req_valid}, 1);
            chk("stall_xy", {req_x, req_y}, p_xy);
            chk("stall_blk", 32'({req_blk_col, req_blk_row, req_row_last}), p_blk);
        end
        if (frame_done) begin
            n_done++;
            chk("done_drained", tb_out, 0);
            chk("done_count", k, BPR * BLK_ROWS);
        end
        res_valid = extra_res;
        extra_res = 1'b0;
        if (res_q.size() > 0 && res_q[0] <= cyc) begin
            void'(res_q.pop_front());
            res_valid = 1'b1;
        end
        buf_release = extra_rel;
        extra_rel = 1'b0;
        if (rel_q.size() > 0 && rel_q[0] <= cyc) begin
            void'(rel_q.pop_front());
            buf_release = 1'b1;
        end
        if (buf_release) n_rel++;
        req_ready = ($urandom_range(99) < ready_pct);
        if (req_valid && req_ready) begin
            chk("inflight_cap", {31'd0, tb_out < MAX_INFLIGHT}, 1);
            chk("col", 32'(req_blk_col), k % BPR);
            chk("row", 32'(req_blk_row), k / BPR);
            chk("x", 32'(req_x), (k % BPR) * BLK_W);
            chk("y", 32'(req_y), (k / BPR) * BLK_H);
            chk("row_last", {31'd0, req_row_last}, ((k % BPR) == BPR - 1) ? 1 : 0);
            if (k % BPR == 0) chk("credit_gate", {31'd0, (k / BPR) <= n_rel + NUM_BUFS - 1}, 1);
            if (lat_res > 0) res_q.push_back(cyc + lat_res);
            if (lat_rel > 0 && (k % BPR) == BPR - 1) rel_q.push_back(cyc + lat_rel);
            k++;
            n_xfer++;
            tb_out++;
        end
        if (res_valid) begin
            if (tb_out > 0) tb_out--;
            n_res++;
            if (n_res == BPR) res12_iter = cyc;
        end
        prev_stall = req_valid && !req_ready;
        p_xy  = {req_x, req_y};
        p_blk = 32'({req_blk_col, req_blk_row, req_row_last});
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset(input string tag);
        prev_stall = 1'b0;
        ready_pct = 0;
        lat_res = 0;
        lat_rel = 0;
        res_q.delete();
        rel_q.delete();
        extra_res = 1'b0;
        extra_rel = 1'b0;
        reset = 1'b1;
        frame_start = 1'b0;
        req_ready = 1'b0;
        res_valid = 1'b0;
        buf_release = 1'b0;
        step();
        chk({tag, "_flags"}, 32'({req_valid, busy, frame_done, err_spurious, err_release, req_row_last}), 0);
        chk({tag, "_xy"}, {req_x, req_y}, 0);
        chk({tag, "_blk"}, 32'({req_blk_col, req_blk_row}), 0);
        reset = 1'b0;
        tb_out = 0;
    endtask

    task automatic start_frame();
        k = 0;
        n_xfer = 0;
        n_done = 0;
        n_rel = 0;
        n_res = 0;
        res12_iter = -1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic finish_frame(input string tag);
        int g;
        g = 0;
        while (!(n_done >= 1 && res_q.size() == 0 && rel_q.size() == 0) && g < 6000) begin
            step();
            g++;
        end
        chk({tag, "_timeout"}, {31'd0, g >= 6000}, 0);
        chk({tag, "_xfers"}, n_xfer, BPR * BLK_ROWS);
        chk({tag, "_done_cycles"}, n_done, 1);
        chk({tag, "_errs"}, 32'({err_spurious, err_release}), 0);
        chk({tag, "_idle"}, 32'({busy, req_valid}), 0);
    endtask

    initial begin
        int g;
        cyc = 0;
        tb_out = 0;
        do_reset("por");

        // Nominal frame with a stray frame_start mid-frame.
        ready_pct = 100; lat_res = 3; lat_rel = 20;
        start_frame();
        chk("start_lat1", {31'd0, req_valid}, 0);
        step();
        chk("start_lat2", {31'd0, req_valid}, 1);
        run(40);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        finish_frame("nominal");

        // Back-to-back frame under 50% backpressure.
        ready_pct = 50;
        start_frame();
        finish_frame("backpressure");

        // Inflight cap with completions withheld.
        do_reset("rst_cap");
        ready_pct = 100; lat_res = 0; lat_rel = 0;
        start_frame();
        run(15);
        chk("cap_xfers", n_xfer, MAX_INFLIGHT);
        chk("cap_valid", {31'd0, req_valid}, 0);
        extra_res = 1'b1;
        run(8);
        chk("cap_one_more", n_xfer, MAX_INFLIGHT + 1);
        chk("cap_valid2", {31'd0, req_valid}, 0);

        // Buffer gating with no releases.
        do_reset("rst_gate");
        ready_pct = 100; lat_res = 3; lat_rel = 0;
        start_frame();
        run(150);
        chk("gate_xfers", n_xfer, 2 * BPR);
        chk("gate_stall", 32'({busy, req_valid}), 2);
        extra_rel = 1'b1;
        run(40);
        chk("gate_row2", n_xfer, 3 * BPR);

        // Release on the same cycle as the row-1 credit take.
        do_reset("rst_sim");
        ready_pct = 100; lat_res = 3; lat_rel = 0;
        start_frame();
        g = 0;
        while (res12_iter < 0 && g < 300) begin
            step();
            g++;
        end
        chk("sim_timeout", {31'd0, res12_iter < 0}, 0);
        while (cyc < res12_iter + 1) step();
        extra_rel = 1'b1;
        step();
        run(150);
        chk("sim_xfers", n_xfer, 3 * BPR);
        chk("sim_err_release", {31'd0, err_release}, 0);

        // Spurious completion and extra release raise sticky errors only.
        do_reset("rst_err");
        extra_res = 1'b1;
        run(2);
        chk("spurious_set", 32'({err_spurious, err_release}), 2);
        extra_rel = 1'b1;
        run(4);
        chk("release_set", 32'({err_spurious, err_release}), 3);

        // Frame still runs, then reset lands mid-row 5.
        ready_pct = 100; lat_res = 3; lat_rel = 20;
        start_frame();
        g = 0;
        while (k < 5 * BPR + 3 && g < 3000) begin
            step();
            g++;
        end
        chk("row5_reached", {31'd0, k >= 5 * BPR + 3}, 1);
        do_reset("rst_mid");

        ready_pct = 100; lat_res = 3; lat_rel = 20;
        start_frame();
        g = 0;
        while (n_xfer < BPR + 1 && g < 200) begin
            step();
            g++;
        end
        chk("restart_xfers", {31'd0, n_xfer >= BPR + 1}, 1);
        chk("restart_errs", 32'({err_spurious, err_release}), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
